// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch responder:
//   - FSM state encoding (5 states, 3 bits)
//   - wait-state limits and counter width
//   - helper for the byte-address to word-index width derivation
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_READ    = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_ERROR   = 3'd4;

  localparam int MAX_WAIT_STATES = 15;
  localparam int WAIT_CNT_WIDTH  = 4;

  // Word index drops the two byte-offset bits of a 32-bit word address.
  function automatic int wordIndexWidth(input int addrWidth);
    return addrWidth - 2;
  endfunction

endpackage

// File: rtl/fetch_responder_wait_state_counter.sv
// -----------------------------------------------------------------------------
// wait_state_counter
// Loadable 4-bit down-counter used to time SRAM wait states.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-low reset (count -> 0)
//   load       in   load loadValue (has priority over enable)
//   enable     in   decrement by one while count > 1
//   loadValue  in   value loaded on load
//   terminal   out  count == 1
// The counter never wraps: it saturates at 1 so a stray enable cannot
// roll it over to 15.
// -----------------------------------------------------------------------------
module wait_state_counter
  import fetch_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic                      enable,
  input  logic [WAIT_CNT_WIDTH-1:0] loadValue,
  output logic                      terminal
);

  logic [WAIT_CNT_WIDTH-1:0] count_r;

  // Down-counter register with load priority and saturation at 1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= {WAIT_CNT_WIDTH{1'b0}};
    end else if (load) begin
      count_r <= loadValue;
    end else if (enable && (count_r > 4'd1)) begin
      count_r <= count_r - 4'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign terminal = (count_r == 4'd1);

endmodule

// File: rtl/fetch_responder.sv
// -----------------------------------------------------------------------------
// fetch_responder
// Memory-side responder for instruction fetch. Accepts a fetch strobe while
// idle, reads a synchronous instruction SRAM with WAIT_STATES extra cycles,
// and returns the word with valid / misalignment-error status.
// Ports:
//   clk                 in   clock, rising edge
//   reset               in   synchronous active-low reset
//   fetch_RequestState  in   fetch request strobe
//   fetchAddress        in   byte address, sampled with the strobe
//   memEnable           out  SRAM read enable (one cycle, in READ)
//   memAddress          out  SRAM word index (latched request index)
//   memReadData         in   SRAM read data, valid in the CAPTURE cycle
//   instruction         out  returned word (0 for a misaligned request)
//   instructionValid    out  instruction holds the last accepted result
//   fetchError          out  last accepted request was misaligned
//   fetchBusy           out  state is not IDLE
//   requestDropped      out  one-cycle pulse: strobe seen while busy
// -----------------------------------------------------------------------------
module fetch_responder
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 0
)(
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  fetch_RequestState,
  input  logic [ADDR_WIDTH-1:0]                 fetchAddress,
  output logic                                  memEnable,
  output logic [wordIndexWidth(ADDR_WIDTH)-1:0] memAddress,
  input  logic [DATA_WIDTH-1:0]                 memReadData,
  output logic [DATA_WIDTH-1:0]                 instruction,
  output logic                                  instructionValid,
  output logic                                  fetchError,
  output logic                                  fetchBusy,
  output logic                                  requestDropped
);

  localparam int INDEX_WIDTH = wordIndexWidth(ADDR_WIDTH);
  // Out-of-range settings are clamped to the longest supported wait.
  localparam int WAIT_CLAMPED = (WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES : WAIT_STATES;
  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD = WAIT_CNT_WIDTH'(WAIT_CLAMPED);

  logic [2:0]             state_r;
  logic [2:0]             nextState_s;
  logic [INDEX_WIDTH-1:0] wordIndex_r;
  logic                   memEnable_r;
  logic [DATA_WIDTH-1:0]  instruction_r;
  logic                   instructionValid_r;
  logic                   fetchError_r;
  logic                   requestDropped_r;
  logic                   accept_s;
  logic                   aligned_s;
  logic                   waitLoad_s;
  logic                   waitEnable_s;
  logic                   waitTerminal_s;

  assign accept_s     = fetch_RequestState && (state_r == ST_IDLE);
  assign aligned_s    = (fetchAddress[1:0] == 2'b00);
  assign waitLoad_s   = (state_r == ST_READ);
  assign waitEnable_s = (state_r == ST_WAIT);

  wait_state_counter u_waitCounter (
    .clk       (clk),
    .reset     (reset),
    .load      (waitLoad_s),
    .enable    (waitEnable_s),
    .loadValue (WAIT_LOAD),
    .terminal  (waitTerminal_s)
  );

  // Next-state logic for the fetch sequencer.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (fetch_RequestState) begin
          if (aligned_s) begin
            nextState_s = ST_READ;
          end else begin
            nextState_s = ST_ERROR;
          end
        end else begin
          nextState_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (WAIT_LOAD == 4'd0) begin
          nextState_s = ST_CAPTURE;
        end else begin
          nextState_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (waitTerminal_s) begin
          nextState_s = ST_CAPTURE;
        end else begin
          nextState_s = ST_WAIT;
        end
      end
      ST_CAPTURE: nextState_s = ST_IDLE;
      ST_ERROR:   nextState_s = ST_IDLE;
      default:    nextState_s = ST_IDLE;
    endcase
  end

  // State register, SRAM enable and drop pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r          <= ST_IDLE;
      memEnable_r      <= 1'b0;
      requestDropped_r <= 1'b0;
    end else begin
      state_r          <= nextState_s;
      // Enable is registered so it is high exactly while the state is READ.
      memEnable_r      <= accept_s && aligned_s;
      requestDropped_r <= fetch_RequestState && (state_r != ST_IDLE);
    end
  end

  // Word-index latch; a misaligned request leaves the previous index in place.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wordIndex_r <= {INDEX_WIDTH{1'b0}};
    end else if (accept_s && aligned_s) begin
      wordIndex_r <= fetchAddress[ADDR_WIDTH-1:2];
    end else begin
      wordIndex_r <= wordIndex_r;
    end
  end

  // Result registers: cleared status on accept, loaded on completion.
  always_ff @(posedge clk) begin
    if (!reset) begin
      instruction_r      <= {DATA_WIDTH{1'b0}};
      instructionValid_r <= 1'b0;
      fetchError_r       <= 1'b0;
    end else if (accept_s) begin
      instruction_r      <= instruction_r;
      instructionValid_r <= 1'b0;
      fetchError_r       <= 1'b0;
    end else if (state_r == ST_CAPTURE) begin
      instruction_r      <= memReadData;
      instructionValid_r <= 1'b1;
      fetchError_r       <= 1'b0;
    end else if (state_r == ST_ERROR) begin
      instruction_r      <= {DATA_WIDTH{1'b0}};
      instructionValid_r <= 1'b1;
      fetchError_r       <= 1'b1;
    end else begin
      instruction_r      <= instruction_r;
      instructionValid_r <= instructionValid_r;
      fetchError_r       <= fetchError_r;
    end
  end

  assign memEnable        = memEnable_r;
  assign memAddress       = wordIndex_r;
  assign instruction      = instruction_r;
  assign instructionValid = instructionValid_r;
  assign fetchError       = fetchError_r;
  assign requestDropped   = requestDropped_r;
  // Busy is decoded straight from state so the pipeline sees it without delay.
  assign fetchBusy        = (state_r != ST_IDLE);

endmodule

// File: doc/fetch_responder.md
# fetch_responder

Memory-side responder for instruction fetch. It answers the fetch request strobe issued by the pipeline state sequencer, performs the read against a synchronous instruction SRAM with a configurable number of wait states, and returns the instruction word with a valid/error indication. It also exports a busy flag that the pipeline uses for stall control.

## Interface
- ADDR_WIDTH, 16: byte-address width.
- DATA_WIDTH, 32: instruction word width.
- WAIT_STATES, 0: extra SRAM read cycles. Legal range is 0..15.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- fetch_RequestState  in  1  fetch request strobe; sampled on each rising edge.
- fetchAddress  in  ADDR_WIDTH  byte address; sampled with the strobe.
- memEnable  out  1  SRAM read enable.
- memAddress  out  ADDR_WIDTH-2  SRAM word index.
- memReadData  in  DATA_WIDTH  SRAM read data; valid WAIT_STATES+1 cycles after the memEnable cycle.
- instruction  out  DATA_WIDTH  returned word.
- instructionValid  out  1  instruction holds the result of the last accepted request.
- fetchError  out  1  last accepted request was misaligned.
- fetchBusy  out  1  a request is in flight (state is not IDLE).
- requestDropped  out  1  one-cycle pulse: a request arrived while busy.

## Operation
- States: IDLE, READ, WAIT, CAPTURE, ERROR.
- IDLE + strobe, with fetchAddress[1:0]==0:
  - Latch word index = fetchAddress[ADDR_WIDTH-1:2].
  - Clear instructionValid and fetchError.
  - Go to READ.
- IDLE + strobe, with fetchAddress[1:0]!=0:
  - Clear instructionValid and fetchError.
  - Go to ERROR. No SRAM access occurs.
- READ:
  - memEnable=1; memAddress = latched index.
  - Load waitCount = WAIT_STATES.
  - Next state is CAPTURE if WAIT_STATES==0, else WAIT.
- WAIT:
  - memEnable=0; waitCount decrements each cycle.
  - When waitCount==1, next state is CAPTURE. WAIT therefore lasts exactly WAIT_STATES cycles.
- CAPTURE: register memReadData into instruction, set instructionValid=1, go to IDLE.
- ERROR: instruction=0, instructionValid=1, fetchError=1, go to IDLE.
- Requests are accepted only in IDLE.
  - A strobe in any other state is ignored and pulses requestDropped in the following cycle.
  - The in-flight access is unaffected.
- instruction, instructionValid and fetchError hold their values until the next accepted request or reset.
- memAddress holds the latched index in every state. It is 0 after reset until the first accept.
- waitCount width is 4 bits and never wraps: it is loaded only in READ and stops at 1.

## Timing
- Reset values (reset==0 at an edge take effect after that edge):
  - state=IDLE.
  - memEnable=0, memAddress=0.
  - instruction=0, instructionValid=0, fetchError=0.
  - fetchBusy=0, requestDropped=0, waitCount=0.
- Reset mid-operation: return to IDLE on the next edge. The pending SRAM data is discarded and no valid is produced.
- Reset has priority over a simultaneous strobe.
- Aligned-request latency, with the request sampled at edge E0:
  - READ occupies the cycle after E0.
  - WAIT occupies the next WAIT_STATES cycles.
  - CAPTURE occupies the following cycle.
  - instructionValid is high after edge E0+2+WAIT_STATES.
- Misaligned-request latency: instructionValid and fetchError are high after edge E0+1.
- fetchBusy is combinational from state and is high from after E0 until the cycle before IDLE returns.
- A strobe in the same cycle that CAPTURE or ERROR completes is dropped, because the state is not yet IDLE.
- Back-to-back throughput: one request per 3+WAIT_STATES cycles.

## Structure
- Shared package `fetch_pkg` holds:
  - the state encoding (5 states, 3 bits);
  - the MAX_WAIT_STATES=15 constant;
  - the width of the word-index derivation.
- One sub-module, `wait_state_counter`: a loadable 4-bit down-counter with load, enable and a terminal (==1) flag.
- Top level: state register, address latch, output registers, drop-pulse register.

## Test plan
- Reset: hold reset=0 for 3 cycles with the strobe high → all outputs 0 and fetchBusy=0.
- WAIT_STATES=0, request at 0x0010, SRAM returns 0xDEADBEEF →
  - memEnable=1 for one cycle with memAddress=0x0004;
  - instruction=0xDEADBEEF, instructionValid=1 after E0+2, held until the next request.
- WAIT_STATES=3, request at 0x0100 →
  - memEnable for one cycle with memAddress=0x0040;
  - fetchBusy for 5 cycles;
  - valid after E0+5.
- Misaligned request at 0x0013 → memEnable never asserts; instruction=0, fetchError=1, instructionValid=1 after E0+1.
- Strobe while in WAIT (WAIT_STATES=2) → requestDropped pulses for 1 cycle; the original request completes with its own data.
- reset=0 during WAIT → next cycle is IDLE, instructionValid stays 0, and a later request to 0x0008 completes normally.
